// File: rtl/hdlc_line_monitor.sv
// hdlc_line_monitor: per-channel HDLC flag/abort/frame monitor with a
// strobe/ack status read port. Channel status word:
//   [7:0]   {idle, ovf, err_len, abort, frame_seen, 1'b0, state[1:0]}
//   [15:8]  last valid frame length in bytes (low 8 bits)
//   [23:16] valid frame count, [31:24] length-error count (both wrap)
// Optional feature macro: HDLC_MON_IDLE_EN (idle-line detection on
// 15+ consecutive ones). Without it the idle bit reads 0.
module hdlc_line_monitor #(
    parameter int NCH       = 4,
    parameter int MIN_BYTES = 4,
    parameter int LEN_W     = 12,
    // one extra code point so out-of-range channels can be addressed
    localparam int CH_W     = $clog2(NCH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NCH-1:0]   bit_i,
    input  logic [NCH-1:0]   bit_en_i,
    output logic [NCH-1:0]   flag_o,
    output logic [NCH-1:0]   frame_o,
    output logic [NCH-1:0]   abort_o,
    input  logic             rd_i,
    input  logic [CH_W-1:0]  ch_i,
    output logic             ack_o,
    output logic [31:0]      dat_o
);

    localparam int BC_W = LEN_W + 4;
`ifdef HDLC_MON_IDLE_EN
    localparam int ONES_W = 4;
`else
    localparam int ONES_W = 3;
`endif

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        FLAG  = 2'd1,
        FRAME = 2'd2
    } state_t;

    logic [31:0] stat_w [NCH];
    logic [31:0] rd_stat;
    logic        ack_q;
    logic [31:0] dat_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic               b;
        logic [6:0]         sr_q;
        logic [7:0]         sr_d;
        logic [ONES_W-1:0]  ones_q, ones_d;
        logic [BC_W-1:0]    bitcnt_q, bitcnt_d, len;
        logic [LEN_W:0]     len_bytes;
        logic               is_flag, is_abort, is_stuff, len_ok, len_over, rd_hit;
        state_t             state_q;
        logic               flag_q, frame_q, abort_q, err_q, ovf_q;
        logic               frame_seen_q, abort_st_q, err_len_q, ovf_st_q, idle_w;
        logic [LEN_W-1:0]   last_len_q;
        logic [7:0]         frm_cnt_q, err_cnt_q;

        assign b      = bit_i[g];
        assign rd_hit = rd_i && (ch_i == CH_W'(g));

        // Bit-level decode: shift, ones run, destuff, and closing-flag length.
        // Only 7 history bits are stored; the 8th comes from the incoming bit.
        always_comb begin
            sr_d      = {sr_q, b};
            ones_d    = b ? ((ones_q == '1) ? ones_q : ones_q + 1'b1) : '0;
            is_flag   = (sr_d == 8'h7E);
            is_abort  = b && (ones_q == ONES_W'(6));
            is_stuff  = !b && (ones_q == ONES_W'(5));
            bitcnt_d  = (is_stuff || bitcnt_q == '1) ? bitcnt_q : bitcnt_q + 1'b1;
            // first seven bits of the closing flag are already in bitcnt_q
            len       = bitcnt_q - BC_W'(7);
            len_bytes = len[BC_W-1:3];
            len_over  = len_bytes[LEN_W];
            len_ok    = (len[2:0] == 3'd0) && (len_bytes >= (LEN_W+1)'(MIN_BYTES));
        end

        // Channel FSM, event pulses, counters and sticky status.
        // Stickies are set from the registered pulses, so a read in the
        // pulse cycle clears the old value while the new event sets it again.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sr_q         <= '0;
                ones_q       <= '0;
                bitcnt_q     <= '0;
                state_q      <= HUNT;
                flag_q       <= 1'b0;
                frame_q      <= 1'b0;
                abort_q      <= 1'b0;
                err_q        <= 1'b0;
                ovf_q        <= 1'b0;
                frame_seen_q <= 1'b0;
                abort_st_q   <= 1'b0;
                err_len_q    <= 1'b0;
                ovf_st_q     <= 1'b0;
                last_len_q   <= '0;
                frm_cnt_q    <= '0;
                err_cnt_q    <= '0;
            end else begin
                flag_q  <= 1'b0;
                frame_q <= 1'b0;
                abort_q <= 1'b0;
                err_q   <= 1'b0;
                ovf_q   <= 1'b0;

                frame_seen_q <= frame_q | (frame_seen_q & ~rd_hit);
                abort_st_q   <= abort_q | (abort_st_q & ~rd_hit);
                err_len_q    <= err_q   | (err_len_q & ~rd_hit);
                ovf_st_q     <= ovf_q   | (ovf_st_q & ~rd_hit);

                if (bit_en_i[g]) begin
                    sr_q     <= sr_d[6:0];
                    ones_q   <= ones_d;
                    bitcnt_q <= bitcnt_d;
                    flag_q   <= is_flag;
                    case (state_q)
                        HUNT: begin
                            if (is_flag) begin
                                state_q  <= FLAG;
                                bitcnt_q <= '0;
                            end
                        end
                        FLAG: begin
                            if (is_abort) begin
                                state_q <= HUNT;
                            end else if (is_flag) begin
                                bitcnt_q <= '0;
                            end else if (bitcnt_d == BC_W'(8)) begin
                                state_q <= FRAME;
                            end
                        end
                        FRAME: begin
                            if (is_abort) begin
                                state_q <= HUNT;
                                abort_q <= 1'b1;
                            end else if (is_flag) begin
                                state_q  <= FLAG;
                                bitcnt_q <= '0;
                                ovf_q    <= len_over;
                                if (len_ok) begin
                                    frame_q    <= 1'b1;
                                    frm_cnt_q  <= frm_cnt_q + 8'd1;
                                    last_len_q <= len_over ? '1 : len_bytes[LEN_W-1:0];
                                end else begin
                                    err_q     <= 1'b1;
                                    err_cnt_q <= err_cnt_q + 8'd1;
                                end
                            end
                        end
                        default: state_q <= HUNT;
                    endcase
`ifdef HDLC_MON_IDLE_EN
                    if (b && ones_q >= ONES_W'(14)) begin
                        state_q <= HUNT;
                    end
`endif
                end
            end
        end

`ifdef HDLC_MON_IDLE_EN
        logic idle_q;
        // Idle status follows the line: set on the 15th one, dropped by a zero.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                idle_q <= 1'b0;
            end else if (bit_en_i[g]) begin
                if (b && ones_q >= ONES_W'(14)) begin
                    idle_q <= 1'b1;
                end else if (!b) begin
                    idle_q <= 1'b0;
                end
            end
        end
        assign idle_w = idle_q;
`else
        assign idle_w = 1'b0;
`endif

        assign flag_o[g]  = flag_q;
        assign frame_o[g] = frame_q;
        assign abort_o[g] = abort_q;
        assign stat_w[g]  = {err_cnt_q, frm_cnt_q, last_len_q[7:0],
                             idle_w, ovf_st_q, err_len_q, abort_st_q, frame_seen_q,
                             1'b0, state_q};
    end

    // Channel select; codes at or above NCH read as zero.
    always_comb begin
        rd_stat = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_i == CH_W'(c)) begin
                rd_stat = stat_w[c];
            end
        end
    end

    // Read port: one registered ack and data word per strobe cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= rd_i;
            dat_q <= rd_i ? rd_stat : 32'd0;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Testbench for hdlc_line_monitor: directed bit streams per channel, read
// expectations pushed into a scoreboard and checked by a separate monitor.
module tb_hdlc_line_monitor;
    localparam int NCH = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NCH-1:0]  bit_i, bit_en_i, flag_o, frame_o, abort_o;
    logic            rd_i;
    logic [2:0]      ch_i;
    logic            ack_o;
    logic [31:0]     dat_o;

    hdlc_line_monitor #(.NCH(NCH), .MIN_BYTES(4), .LEN_W(12)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bit_i(bit_i), .bit_en_i(bit_en_i),
        .flag_o(flag_o), .frame_o(frame_o), .abort_o(abort_o),
        .rd_i(rd_i), .ch_i(ch_i), .ack_o(ack_o), .dat_o(dat_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] msk_q[$];
    int flag_cnt[NCH];
    int frame_cnt[NCH];
    int abort_cnt[NCH];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks every ack against the scoreboard, counts pulses.
    always @(negedge clk_i) begin
        logic [31:0] e, m;
        if (ack_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got dat %h expected no ack", dat_o);
            end else begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                chk("read_data", dat_o & m, e & m);
            end
        end else if (dat_o !== 32'd0) begin
            chk("dat_zero_no_ack", dat_o, 32'd0);
        end
        for (int c = 0; c < NCH; c++) begin
            if (flag_o[c])  flag_cnt[c]++;
            if (frame_o[c]) frame_cnt[c]++;
            if (abort_o[c]) abort_cnt[c]++;
        end
    end

    task automatic send_bit(int ch, logic b);
        bit_i[ch]    = b;
        bit_en_i[ch] = 1'b1;
        @(negedge clk_i);
        bit_en_i[ch] = 1'b0;
    endtask

    task automatic send_byte(int ch, logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(ch, v[i]);
    endtask

    task automatic do_read(int ch, logic [31:0] e, logic [31:0] m);
        exp_q.push_back(e);
        msk_q.push_back(m);
        rd_i = 1'b1;
        ch_i = 3'(ch);
        @(negedge clk_i);
        rd_i = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NCH; c++) begin
            flag_cnt[c] = 0; frame_cnt[c] = 0; abort_cnt[c] = 0;
        end
        rst_i = 1'b1; bit_i = '0; bit_en_i = '0; rd_i = 1'b0; ch_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_flag_o",  32'(flag_o),  32'd0);
        chk("rst_frame_o", 32'(frame_o), 32'd0);
        chk("rst_abort_o", 32'(abort_o), 32'd0);
        chk("rst_ack_o",   32'(ack_o),   32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        do_read(0, 32'h0000_0000, '1);
        do_read(1, 32'h0000_0000, '1);

        // 1: ch0 valid 4-byte frame
        send_byte(0, 8'h7E);
        send_byte(0, 8'h00); send_byte(0, 8'h01);
        send_byte(0, 8'hAA); send_byte(0, 8'h55);
        send_byte(0, 8'h7E);
        settle();
        chk("t1_frame_cnt", 32'(frame_cnt[0]), 32'd1);
        chk("t1_flag_cnt",  32'(flag_cnt[0]),  32'd2);
        do_read(0, 32'h0001_0409, '1);

        // 2: ch1 stuffed zero after five data ones, 6-byte frame
        send_byte(1, 8'h7E);
        for (int i = 0; i < 5; i++) send_bit(1, 1'b1);
        send_bit(1, 1'b0);
        for (int i = 0; i < 43; i++) send_bit(1, 1'b0);
        send_byte(1, 8'h7E);
        settle();
        chk("t2_frame_cnt", 32'(frame_cnt[1]), 32'd1);
        do_read(1, 32'h0001_0609, '1);

        // 3: ch2 abort inside a frame
        send_byte(2, 8'h7E);
        send_byte(2, 8'h00); send_byte(2, 8'h00);
        send_byte(2, 8'h7F);
        settle();
        chk("t3_abort_cnt", 32'(abort_cnt[2]), 32'd1);
        chk("t3_frame_cnt", 32'(frame_cnt[2]), 32'd0);
        do_read(2, 32'h0000_0010, '1);
        do_read(2, 32'h0000_0000, '1);

        // 4: ch3 short frame, then three back-to-back flags
        send_byte(3, 8'h7E);
        send_byte(3, 8'h00); send_byte(3, 8'h00); send_byte(3, 8'h00);
        send_byte(3, 8'h7E);
        send_byte(3, 8'h7E); send_byte(3, 8'h7E); send_byte(3, 8'h7E);
        settle();
        chk("t4_frame_cnt", 32'(frame_cnt[3]), 32'd0);
        chk("t4_flag_cnt",  32'(flag_cnt[3]),  32'd5);
        exp_q.push_back(32'h0100_0021); msk_q.push_back('1);
        exp_q.push_back(32'h0100_0001); msk_q.push_back('1);
        rd_i = 1'b1; ch_i = 3'd3;
        repeat (2) @(negedge clk_i);
        rd_i = 1'b0;

        // 5: read of ch0 in the same cycle as its frame_o pulse
        send_byte(0, 8'h7E);
        for (int i = 0; i < 4; i++) send_byte(0, 8'h00);
        send_byte(0, 8'h7E);
        chk("t5_frame_pulse", 32'(frame_o[0]), 32'd1);
        do_read(0, 32'h0002_0401, 32'hFFFF_FFF7);
        @(negedge clk_i);
        do_read(0, 32'h0002_0409, '1);
        settle();
        chk("t5_frame_cnt", 32'(frame_cnt[0]), 32'd2);

        // 6: out-of-range channel, then reset in mid-frame
        do_read(4, 32'h0000_0000, '1);
        send_byte(0, 8'h7E);
        send_byte(0, 8'h00); send_byte(0, 8'h00);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        send_byte(0, 8'h00); send_byte(0, 8'h00);
        send_byte(0, 8'h7E);
        settle();
        chk("t6_frame_cnt", 32'(frame_cnt[0]), 32'd2);
        do_read(0, 32'h0000_0001, '1);
        do_read(3, 32'h0000_0000, '1);

`ifdef HDLC_MON_IDLE_EN
        for (int i = 0; i < 16; i++) send_bit(2, 1'b1);
        do_read(2, 32'h0000_0080, '1);
        send_bit(2, 1'b0);
        do_read(2, 32'h0000_0000, '1);
`endif

        settle();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
